// File: rtl/aib_rx_word_align.sv
// AIB rx word aligner: pairs 40-bit half-words into 80-bit words using the bit-39 marker, locks/unlocks on marker pairs.
// Latency: dout/dout_vld, wa_slip and wa_lock are registered one rd_clk after the accepting edge.
// Backpressure: none; every din_vld half-word is consumed. Optional AIB_WA_ERR_CNT_EN builds the err_cnt counter.
module aib_rx_word_align #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic        rd_clk,
  input  logic        rd_rstn,
  input  logic        wa_en,
  input  logic [39:0] din,
  input  logic        din_vld,
  output logic [79:0] dout,
  output logic        dout_vld,
  output logic        wa_lock,
  output logic        wa_slip,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_W = 4'(LOSS_CNT);

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic [39:0] lo_q, lo_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [3:0]  gcnt_inc, bcnt_inc;
  logic        pair_good;
  logic        out_fire;
  logic        slip_d;
  logic        err_inc;

  // Good pair: lower half unmarked, upper half marked.
  assign pair_good = ~lo_q[39] & din[39];
  assign gcnt_inc  = gcnt_q + 4'd1;
  assign bcnt_inc  = bcnt_q + 4'd1;

  // Next-state: phase tracking, slip on bad pairs while hunting, lock/loss counting.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    lo_d     = lo_q;
    gcnt_d   = gcnt_q;
    bcnt_d   = bcnt_q;
    out_fire = 1'b0;
    slip_d   = 1'b0;
    err_inc  = 1'b0;
    if (!wa_en) begin
      state_d = SEARCH;
      ph_d    = 1'b0;
      gcnt_d  = 4'd0;
      bcnt_d  = 4'd0;
    end else if (din_vld) begin
      if (!ph_q) begin
        lo_d = din;
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        case (state_q)
          SEARCH: begin
            if (pair_good) begin
              gcnt_d  = 4'd1;
              bcnt_d  = 4'd0;
              state_d = (LOCK_W == 4'd1) ? LOCKED : CONFIRM;
            end else begin
              // Slip by one half-word: this din becomes the new lower half.
              lo_d   = din;
              ph_d   = 1'b1;
              slip_d = 1'b1;
            end
          end
          CONFIRM: begin
            if (pair_good) begin
              gcnt_d = gcnt_inc;
              if (gcnt_inc == LOCK_W) begin
                state_d = LOCKED;
                bcnt_d  = 4'd0;
              end
            end else begin
              state_d = SEARCH;
              gcnt_d  = 4'd0;
              lo_d    = din;
              ph_d    = 1'b1;
              slip_d  = 1'b1;
            end
          end
          LOCKED: begin
            // Every locked pair is delivered, even the one that drops lock.
            out_fire = 1'b1;
            if (pair_good) begin
              bcnt_d = 4'd0;
            end else begin
              bcnt_d  = bcnt_inc;
              err_inc = 1'b1;
              if (bcnt_inc == LOSS_W) begin
                state_d = SEARCH;
                gcnt_d  = 4'd0;
                bcnt_d  = 4'd0;
              end
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  // Alignment state registers.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q <= SEARCH;
      ph_q    <= 1'b0;
      lo_q    <= 40'd0;
      gcnt_q  <= 4'd0;
      bcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lo_q    <= lo_d;
      gcnt_q  <= gcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Registered outputs; dout holds its last word when nothing is delivered.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      dout     <= 80'd0;
      dout_vld <= 1'b0;
      wa_lock  <= 1'b0;
      wa_slip  <= 1'b0;
    end else begin
      if (out_fire) begin
        dout <= {din, lo_q};
      end
      dout_vld <= out_fire;
      wa_lock  <= (state_d == LOCKED);
      wa_slip  <= slip_d;
    end
  end

`ifdef AIB_WA_ERR_CNT_EN
  // Saturating bad-pair counter; survives wa_en drops, cleared only by reset.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      err_cnt <= 16'd0;
    end else if (err_inc && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = 16'h0;
`endif

endmodule

// File: doc/aib_rx_word_align.md
AIB_RX_WORD_ALIGN -- requirements
Module: aib_rx_word_align

Interface
REQ-001 The block SHALL provide parameter LOCK_CNT, default 4, meaning the number of consecutive good marker pairs needed to lock (legal range 1..15).
REQ-002 The block SHALL provide parameter LOSS_CNT, default 2, meaning the number of consecutive bad marker pairs in LOCKED that drop lock (legal range 1..15).
REQ-003 The block SHALL have port rd_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rd_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port wa_en, input, 1 bit: alignment enable.
REQ-006 The block SHALL have port din, input, 40 bits: half-word from the rx FIFO; bit 39 is the word marker.
REQ-007 The block SHALL have port din_vld, input, 1 bit: din qualifier.
REQ-008 The block SHALL have port dout, output, 80 bits: aligned full word {upper half, lower half}.
REQ-009 The block SHALL have port dout_vld, output, 1 bit: dout qualifier.
REQ-010 The block SHALL have port wa_lock, output, 1 bit: high while in LOCKED.
REQ-011 The block SHALL have port wa_slip, output, 1 bit: one-cycle pulse per half-word slip.
REQ-012 The block SHALL have port err_cnt, output, 16 bits: saturating count of bad pairs seen in LOCKED.

Function
REQ-013 Each din_vld half-word SHALL be accepted; phase bit ph=0 stores din into lo, and ph=1 forms pair {din, lo} and toggles ph back to 0. Cycles with din_vld=0 SHALL change nothing.
REQ-014 A pair SHALL be good iff lo[39]=0 and din[39]=1; otherwise it is bad.
REQ-015 FSM states SHALL be SEARCH, CONFIRM and LOCKED, with a 4-bit good counter gcnt and a 4-bit bad counter bcnt.
REQ-016 In SEARCH, a good pair SHALL set gcnt=1 and go to CONFIRM, or go directly to LOCKED if LOCK_CNT=1.
REQ-017 In SEARCH, a bad pair SHALL slip: the current din becomes the new lo, ph stays 1, and wa_slip pulses the following cycle.
REQ-018 In CONFIRM, a good pair SHALL increment gcnt; reaching LOCK_CNT SHALL enter LOCKED with bcnt=0. A bad pair SHALL return to SEARCH with a slip as in REQ-017.
REQ-019 In LOCKED, a good pair SHALL clear bcnt. A bad pair SHALL increment bcnt and err_cnt; reaching LOSS_CNT SHALL enter SEARCH with gcnt=0 and no slip on that pair.
REQ-020 A pair completed while in LOCKED (including the pair that drops lock) SHALL be registered to dout with dout_vld=1 one cycle after the accepting edge; otherwise dout_vld=0 and dout holds its last value.
REQ-021 wa_lock SHALL be a registered decode of state==LOCKED.
REQ-022 wa_en=0 SHALL synchronously force SEARCH, ph=0, gcnt=bcnt=0, dout_vld=0 and wa_slip=0; err_cnt SHALL hold. On the rise of wa_en, search SHALL start from ph=0.
REQ-023 err_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-024 Asserting rd_rstn low SHALL immediately clear state to SEARCH, ph, lo, gcnt, bcnt, dout=0, dout_vld=0, wa_lock=0, wa_slip=0 and err_cnt=0, including mid-pair or mid-lock.
REQ-025 Deassertion SHALL be followed by normal operation from the first rd_clk edge; no input is accepted while rd_rstn=0.

Configuration
REQ-026 Macro AIB_WA_ERR_CNT_EN, when defined, SHALL compile in the err_cnt counter logic.
REQ-027 When AIB_WA_ERR_CNT_EN is undefined, err_cnt SHALL be tied to 16'h0 with no counter flops; all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset, wa_en=1, stream alternating din[39]=0/1 starting with 0 -> wa_lock=1 after exactly the 4th good pair, no wa_slip, and dout_vld on each subsequent pair with dout[79]=1, dout[39]=0.
REQ-029 Same stream but starting with din[39]=1 -> exactly one wa_slip pulse, then lock after 4 good pairs, and dout correctly phased.
REQ-030 While locked, inject 1 bad pair then good -> wa_lock stays 1 and err_cnt=1; inject 2 consecutive bad pairs -> wa_lock=0 after the 2nd and err_cnt=3.
REQ-031 din_vld gapped randomly at 50% with a correct stream -> same lock point measured in pairs, and no dout_vld without a completed pair.
REQ-032 Assert rd_rstn low mid-LOCKED -> all outputs 0 asynchronously; drop wa_en for 1 cycle while locked -> wa_lock=0, relock after 4 pairs, err_cnt unchanged.
REQ-033 Build without AIB_WA_ERR_CNT_EN and repeat REQ-030 -> err_cnt stays 0 and lock/loss timing is identical.
